ramio_arbiter: RTL and testbench

RAMIO_ARBITER -- requirements
Module: ramio_arbiter

---
 rtl/ramio_arbiter.sv | 118 +++++++++++
 tb/tb_ramio_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramio_arbiter.sv
// ramio_arbiter: two-requester arbiter sharing one downstream RAM I/O port
// Ports: clk/rst_n (async active-low); m0_*/m1_* requester side (enable, read/write type,
// address, write data in; read data, ready pulse, busy out); ramio_* downstream side;
// grant = requester currently/last served; timeout_err = one-cycle abort pulse.
module ramio_arbiter #(
  parameter int RoundRobin    = 1,
  parameter int TimeoutCycles = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_enable,
  input  logic [2:0]  m0_read_type,
  input  logic [1:0]  m0_write_type,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_data_in,
  output logic [31:0] m0_data_out,
  output logic        m0_data_out_ready,
  output logic        m0_busy,
  input  logic        m1_enable,
  input  logic [2:0]  m1_read_type,
  input  logic [1:0]  m1_write_type,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_data_in,
  output logic [31:0] m1_data_out,
  output logic        m1_data_out_ready,
  output logic        m1_busy,
  output logic        ramio_enable,
  output logic [2:0]  ramio_read_type,
  output logic [1:0]  ramio_write_type,
  output logic [31:0] ramio_address,
  output logic [31:0] ramio_data_in,
  input  logic [31:0] ramio_data_out,
  input  logic        ramio_data_out_ready,
  input  logic        ramio_busy,
  output logic        grant,
  output logic        timeout_err
);
  typedef enum logic [1:0] {Idle, Issue, Wait, Gap} state_t;
  state_t      state_q;
  logic        req0, req1, sel, done, expired;
  logic [2:0]  rt_q;
  logic [1:0]  wt_q;
  logic [31:0] addr_q, din_q, cnt_q, rd_data;
  assign req0 = m0_enable && (m0_read_type != 3'd0 || m0_write_type != 2'd0);
  assign req1 = m1_enable && (m1_read_type != 3'd0 || m1_write_type != 2'd0);
  // on a tie, round-robin hands the port to whoever did not hold it last
  assign sel = (req0 && req1) ? (RoundRobin != 0 && !grant) : req1;
  assign done = (wt_q != 2'd0) ? !ramio_busy : ramio_data_out_ready;
  assign expired = cnt_q == 32'(TimeoutCycles - 1);
  assign rd_data = done ? ramio_data_out : 32'd0;
  assign m0_busy = req0 && !(state_q == Gap && !grant);
  assign m1_busy = req1 && !(state_q == Gap && grant);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= Idle;
      grant             <= 1'b1;
      rt_q              <= 3'd0;
      wt_q              <= 2'd0;
      addr_q            <= 32'd0;
      din_q             <= 32'd0;
      cnt_q             <= 32'd0;
      ramio_enable      <= 1'b0;
      ramio_read_type   <= 3'd0;
      ramio_write_type  <= 2'd0;
      ramio_address     <= 32'd0;
      ramio_data_in     <= 32'd0;
      m0_data_out       <= 32'd0;
      m1_data_out       <= 32'd0;
      m0_data_out_ready <= 1'b0;
      m1_data_out_ready <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      m0_data_out_ready <= 1'b0;
      m1_data_out_ready <= 1'b0;
      timeout_err       <= 1'b0;
      case (state_q)
        Idle: if (req0 || req1) begin
          grant   <= sel;
          // a write wins when both types are set, so the read type is dropped
          rt_q    <= sel ? (m1_write_type != 2'd0 ? 3'd0 : m1_read_type)
                         : (m0_write_type != 2'd0 ? 3'd0 : m0_read_type);
          wt_q    <= sel ? m1_write_type : m0_write_type;
          addr_q  <= sel ? m1_address : m0_address;
          din_q   <= sel ? m1_data_in : m0_data_in;
          state_q <= Issue;
        end
        Issue: begin
          ramio_enable     <= 1'b1;
          ramio_read_type  <= rt_q;
          ramio_write_type <= wt_q;
          ramio_address    <= addr_q;
          ramio_data_in    <= din_q;
          cnt_q            <= 32'd0;
          state_q          <= Wait;
        end
        Wait: if (done || expired) begin
          ramio_enable     <= 1'b0;
          ramio_read_type  <= 3'd0;
          ramio_write_type <= 2'd0;
          timeout_err      <= !done;
          state_q          <= Gap;
          if (wt_q == 2'd0) begin
            if (grant) begin
              m1_data_out       <= rd_data;
              m1_data_out_ready <= 1'b1;
            end else begin
              m0_data_out       <= rd_data;
              m0_data_out_ready <= 1'b1;
            end
          end
        end else begin
          cnt_q <= cnt_q + 32'd1;
        end
        default: state_q <= Idle;
      endcase
    end
  end
endmodule

// File: tb/tb_ramio_arbiter.sv
// tb_ramio_arbiter: randomized and directed checks of ramio_arbiter against a behavioural model
module tb_ramio_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_en, m1_en;
  logic [2:0] m0_rt, m1_rt;
  logic [1:0] m0_wt, m1_wt;
  logic [31:0] m0_addr, m1_addr, m0_din, m1_din;
  logic [31:0] m0_dout, m1_dout;
  logic m0_rdy, m1_rdy, m0_busy, m1_busy;
  logic ra_en, ra_rdy, ra_busy, grant, tmo;
  logic [2:0] ra_rt;
  logic [1:0] ra_wt;
  logic [31:0] ra_addr, ra_din, ra_dout;
  logic [31:0] b_m0_dout, b_m1_dout, b_addr, b_din;
  logic b_m0_rdy, b_m1_rdy, b_m0_busy, b_m1_busy, b_en, b_grant, b_tmo;
  logic [2:0] b_rt;
  logic [1:0] b_wt;
  int checks = 0, failures = 0;
  int lat = 1, wcnt = 0, en_cycles = 0, rdy0 = 0, rdy1 = 0;
  bit hang = 0, last = 1, prev_en = 0, b_prev = 0;
  logic [1:0] r_cur = 2'b00, r_hist = 2'b00;
  bit grants[$], b_grants[$];

  always #5 clk = ~clk;

  ramio_arbiter #(.RoundRobin(1), .TimeoutCycles(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_enable(m0_en), .m0_read_type(m0_rt), .m0_write_type(m0_wt), .m0_address(m0_addr),
    .m0_data_in(m0_din), .m0_data_out(m0_dout), .m0_data_out_ready(m0_rdy), .m0_busy(m0_busy),
    .m1_enable(m1_en), .m1_read_type(m1_rt), .m1_write_type(m1_wt), .m1_address(m1_addr),
    .m1_data_in(m1_din), .m1_data_out(m1_dout), .m1_data_out_ready(m1_rdy), .m1_busy(m1_busy),
    .ramio_enable(ra_en), .ramio_read_type(ra_rt), .ramio_write_type(ra_wt),
    .ramio_address(ra_addr), .ramio_data_in(ra_din), .ramio_data_out(ra_dout),
    .ramio_data_out_ready(ra_rdy), .ramio_busy(ra_busy), .grant(grant), .timeout_err(tmo));

  ramio_arbiter #(.RoundRobin(0), .TimeoutCycles(8)) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .m0_enable(m0_en), .m0_read_type(m0_rt), .m0_write_type(m0_wt), .m0_address(m0_addr),
    .m0_data_in(m0_din), .m0_data_out(b_m0_dout), .m0_data_out_ready(b_m0_rdy), .m0_busy(b_m0_busy),
    .m1_enable(m1_en), .m1_read_type(m1_rt), .m1_write_type(m1_wt), .m1_address(m1_addr),
    .m1_data_in(m1_din), .m1_data_out(b_m1_dout), .m1_data_out_ready(b_m1_rdy), .m1_busy(b_m1_busy),
    .ramio_enable(b_en), .ramio_read_type(b_rt), .ramio_write_type(b_wt),
    .ramio_address(b_addr), .ramio_data_in(b_din), .ramio_data_out(32'h0),
    .ramio_data_out_ready(b_en), .ramio_busy(1'b0), .grant(b_grant), .timeout_err(b_tmo));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return a == 32'h100 ? 32'h1234_5678 : a ^ 32'hC0DE_0000;
  endfunction

  function automatic bit busy_of(input bit n);
    return n ? m1_busy : m0_busy;
  endfunction

  function automatic logic [31:0] dout_of(input bit n);
    return n ? m1_dout : m0_dout;
  endfunction

  task automatic set_req(input bit n, input bit en, input logic [2:0] rt, input logic [1:0] wt,
                         input logic [31:0] addr, input logic [31:0] din);
    if (n) begin
      m1_en = en; m1_rt = rt; m1_wt = wt; m1_addr = addr; m1_din = din;
    end else begin
      m0_en = en; m0_rt = rt; m0_wt = wt; m0_addr = addr; m0_din = din;
    end
  endtask

  // one clock: downstream responder, arbitration model, pulse counters
  task automatic tick();
    bit g;
    logic [1:0] wt_e;
    @(posedge clk);
    #1;
    r_hist = r_cur;
    r_cur = {m1_en && (m1_rt != 0 || m1_wt != 0), m0_en && (m0_rt != 0 || m0_wt != 0)};
    wcnt = ra_en ? wcnt + 1 : 0;
    if (ra_en) en_cycles++;
    if (m0_rdy) rdy0++;
    if (m1_rdy) rdy1++;
    ra_rdy = ra_en && ra_wt == 0 && wcnt == lat && !hang;
    ra_busy = ra_en && (hang || wcnt < lat);
    ra_dout = rd_fn(ra_addr);
    if (ra_en && !prev_en) begin
      g = (r_hist == 2'b11) ? !last : r_hist[1];
      wt_e = g ? m1_wt : m0_wt;
      chk("arb_grant", 32'(grant), 32'(g));
      chk("arb_addr", ra_addr, g ? m1_addr : m0_addr);
      chk("arb_wt", 32'(ra_wt), 32'(wt_e));
      chk("arb_rt", 32'(ra_rt), wt_e != 0 ? 32'd0 : 32'(g ? m1_rt : m0_rt));
      last = g;
      grants.push_back(grant);
    end
    if (b_en && !b_prev) b_grants.push_back(b_grant);
    prev_en = ra_en;
    b_prev = b_en;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    last = 1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // issue one access from requester n and wait for its Gap cycle; leaves the arbiter in Idle
  task automatic do_access(input bit n, input logic [2:0] rt, input logic [1:0] wt,
                           input logic [31:0] addr, input logic [31:0] din,
                           output int ncyc, output bit rdy, output logic [31:0] dout, output bit to);
    set_req(n, 1, rt, wt, addr, din);
    ncyc = 0;
    en_cycles = 0;
    do begin
      tick();
      ncyc++;
    end while (busy_of(n) && ncyc < 200);
    if (ncyc >= 200) chk("access_stall", 32'(ncyc), 32'd0);
    rdy = n ? m1_rdy : m0_rdy;
    dout = dout_of(n);
    to = tmo;
    chk("gap_enable_low", 32'(ra_en), 32'd0);
    set_req(n, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    int nc, r0, r1, done_n;
    bit rd, to, m1_ok;
    logic [31:0] dv;
    bit act[2];
    bit isrd[2];
    logic [31:0] raddr[2];
    logic [1:0] wt;
    logic [2:0] rt;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    ra_rdy = 0; ra_busy = 0; ra_dout = 0;
    tick();
    tick();
    chk("rst_enable", 32'(ra_en), 32'd0);
    chk("rst_types", {27'd0, ra_rt, ra_wt}, 32'd0);
    chk("rst_addr", ra_addr | ra_din, 32'd0);
    chk("rst_grant", 32'(grant), 32'd1);
    chk("rst_dout", m0_dout | m1_dout, 32'd0);
    chk("rst_pulses", {29'd0, m0_rdy, m1_rdy, tmo}, 32'd0);
    rst_n = 1'b1;
    tick();
    // single m0 word read returned two cycles after enable
    r0 = rdy0; r1 = rdy1; lat = 2;
    do_access(0, 3'b010, 2'b00, 32'h100, 32'h0, nc, rd, dv, to);
    chk("rd_cycles", 32'(nc), 32'd4);
    chk("rd_data", dv, 32'h1234_5678);
    chk("rd_ready", 32'(rd), 32'd1);
    chk("rd_one_pulse", 32'(rdy0 - r0), 32'd1);
    chk("rd_m1_untouched", 32'(rdy1 - r1) | m1_dout, 32'd0);
    chk("rd_hold", m0_dout, 32'h1234_5678);
    // simultaneous m0 write and m1 read after reset
    do_reset();
    lat = 1;
    grants.delete();
    set_req(0, 1, 3'b000, 2'b11, 32'h200, 32'hDEAD_BEEF);
    set_req(1, 1, 3'b010, 2'b00, 32'h300, 32'h0);
    m1_ok = 1;
    nc = 0;
    do begin
      tick();
      nc++;
      m1_ok &= m1_busy;
    end while (m0_busy && nc < 50);
    set_req(0, 0, 0, 0, 0, 0);
    nc = 0;
    do begin
      tick();
      nc++;
    end while (m1_busy && nc < 50);
    chk("tie_m1_busy", 32'(m1_ok), 32'd1);
    chk("tie_m1_data", m1_dout, rd_fn(32'h300));
    chk("tie_m1_ready", 32'(m1_rdy), 32'd1);
    chk("tie_grant_count", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) chk("tie_grant_seq", {30'd0, grants[0], grants[1]}, 32'b01);
    set_req(1, 0, 0, 0, 0, 0);
    tick();
    // both requesting continuously: round-robin alternates, fixed priority starves m1
    do_reset();
    grants.delete();
    b_grants.delete();
    set_req(0, 1, 3'b000, 2'b11, 32'h10, 32'h1);
    set_req(1, 1, 3'b000, 2'b10, 32'h20, 32'h2);
    nc = 0;
    while (grants.size() < 6 && nc < 100) begin
      tick();
      nc++;
    end
    chk("rr_count", 32'(grants.size()), 32'd6);
    chk("fixed_count", 32'(b_grants.size()), 32'd6);
    for (int i = 0; i < 6 && i < grants.size() && i < b_grants.size(); i++) begin
      chk("rr_grant", 32'(grants[i]), 32'(i % 2));
      chk("fixed_grant", 32'(b_grants[i]), 32'd0);
    end
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    do_reset();
    // write held busy for 5 Wait cycles
    lat = 6;
    do_access(0, 3'b000, 2'b01, 32'h80, 32'h55, nc, rd, dv, to);
    chk("wr_busy_cycles", 32'(nc), 32'd8);
    chk("wr_enable_cycles", 32'(en_cycles), 32'd6);
    chk("wr_no_ready", 32'(rd), 32'd0);
    // timeout on a read that never returns
    lat = 1;
    do_access(0, 3'b110, 2'b00, 32'h44, 32'h0, nc, rd, dv, to);
    chk("pre_to_data", dv, rd_fn(32'h44));
    hang = 1;
    do_access(0, 3'b010, 2'b00, 32'h48, 32'h0, nc, rd, dv, to);
    chk("to_cycles", 32'(nc), 32'd10);
    chk("to_enable_cycles", 32'(en_cycles), 32'd8);
    chk("to_err", 32'(to), 32'd1);
    chk("to_ready", 32'(rd), 32'd1);
    chk("to_data", dv, 32'd0);
    chk("to_err_pulse", 32'(tmo), 32'd0);
    hang = 0;
    do_access(1, 3'b001, 2'b00, 32'h4C, 32'h0, nc, rd, dv, to);
    chk("post_to_cycles", 32'(nc), 32'd3);
    chk("post_to_data", dv, rd_fn(32'h4C));
    // reset during Wait abandons the access
    hang = 1;
    set_req(0, 1, 3'b010, 2'b00, 32'h60, 32'h0);
    r0 = rdy0;
    repeat (3) tick();
    chk("mid_wait_enable", 32'(ra_en), 32'd1);
    #2 rst_n = 1'b0;
    last = 1;
    #1;
    chk("mid_rst_enable", 32'(ra_en), 32'd0);
    set_req(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    hang = 0;
    chk("mid_rst_no_ready", 32'(rdy0 - r0), 32'd0);
    tick();
    do_access(1, 3'b010, 2'b00, 32'h500, 32'h0, nc, rd, dv, to);
    chk("after_rst_cycles", 32'(nc), 32'd3);
    chk("after_rst_data", dv, rd_fn(32'h500));
    // random traffic from both requesters
    do_reset();
    act[0] = 0; act[1] = 0;
    done_n = 0;
    for (int c = 0; c < 4000 && done_n < 80; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (act[n] && !busy_of(n[0])) begin
          chk("rnd_ready", 32'(n ? m1_rdy : m0_rdy), 32'(isrd[n]));
          if (isrd[n]) chk("rnd_data", dout_of(n[0]), rd_fn(raddr[n]));
          act[n] = 0;
          done_n++;
          set_req(n[0], 0, 0, 0, 0, 0);
        end
        if (!act[n] && $urandom_range(0, 2) == 0) begin
          wt = 2'($urandom_range(0, 3));
          rt = 3'(wt == 0 ? $urandom_range(1, 7) : $urandom_range(0, 7));
          raddr[n] = $urandom;
          isrd[n] = wt == 0;
          act[n] = 1;
          set_req(n[0], 1, rt, wt, raddr[n], $urandom);
        end
      end
      if (!ra_en) lat = $urandom_range(1, 4);
      tick();
    end
    chk("rnd_completed", 32'(done_n >= 80), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
